// File: rtl/tia_pkg.sv
// Shared types and constants for the TIA player graphics path.
package tia_pkg;

    localparam int GRP_WIDTH = 8;
    localparam int GS_WIDTH  = 3;

    typedef logic [GRP_WIDTH-1:0] grp_t;
    typedef logic [GS_WIDTH-1:0]  gs_idx_t;

    // Returns the graphics bit addressed by a scan index.
    function automatic logic grp_bit(input grp_t g, input gs_idx_t idx);
        return g[idx];
    endfunction

endpackage

// File: rtl/tia_grp_write_stage.sv
// CPU write staging for one GRPx register: holds the staged byte and the
// pending new/copy requests, and releases them on the colour-clock commit.
module tia_grp_write_stage
    import tia_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  grp_t d,
    input  logic grp_write,
    input  logic other_grp_write,
    input  logic commit,
    output logic load_new,
    output logic load_old,
    output grp_t load_data,
    output logic write_overrun
);

    grp_t stage_data;
    logic pend_new;
    logic pend_copy;
    logic overrun;

    grp_t eff_data;
    logic eff_pend_new;
    logic eff_pend_copy;
    logic overrun_hit;

    // Merge this cycle's strobes with what is already staged so a strobe
    // coincident with commit is committed on the same edge with today's d.
    always_comb begin
        eff_data      = stage_data;
        eff_pend_new  = pend_new | grp_write;
        eff_pend_copy = pend_copy | other_grp_write;
        if (grp_write) begin
            eff_data = d;
        end else begin
            eff_data = stage_data;
        end
        load_new    = commit & eff_pend_new;
        load_old    = commit & eff_pend_copy;
        load_data   = eff_data;
        // Only a second data write replacing an uncommitted one is an overrun;
        // repeated copy requests collapse silently.
        overrun_hit = grp_write & pend_new & ~commit;
    end

    // Staging registers: capture strobes, clear on commit, sticky overrun.
    always_ff @(posedge clock) begin
        if (reset) begin
            stage_data <= 8'h00;
            pend_new   <= 1'b0;
            pend_copy  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            stage_data <= eff_data;
            overrun    <= overrun | overrun_hit;
            if (commit) begin
                pend_new  <= 1'b0;
                pend_copy <= 1'b0;
            end else begin
                pend_new  <= eff_pend_new;
                pend_copy <= eff_pend_copy;
            end
        end
    end

    assign write_overrun = overrun;

endmodule

// File: rtl/tia_player_graphics_register.sv
// One player's GRPx register pair (new and vertical-delay old copy) with the
// scan-index bit select feeding the player graphics scan counter.
module tia_player_graphics_register
    import tia_pkg::*;
#(
    parameter int GRP_WIDTH        = tia_pkg::GRP_WIDTH,
    parameter int REGISTER_OUTPUTS = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [GRP_WIDTH-1:0] d,
    input  logic                 grp_write,
    input  logic                 other_grp_write,
    input  logic                 commit,
    input  logic                 gs0,
    input  logic                 gs1,
    input  logic                 gs2,
    output logic                 new_bit,
    output logic                 old_bit,
    output logic [GRP_WIDTH-1:0] grp_new,
    output logic [GRP_WIDTH-1:0] grp_old,
    output logic                 write_overrun
);

    grp_t    new_q;
    grp_t    old_q;
    grp_t    load_data;
    logic    load_new;
    logic    load_old;
    gs_idx_t idx;
    logic    sel_new;
    logic    sel_old;

    tia_grp_write_stage u_stage (
        .clock           (clock),
        .reset           (reset),
        .d               (d),
        .grp_write       (grp_write),
        .other_grp_write (other_grp_write),
        .commit          (commit),
        .load_new        (load_new),
        .load_old        (load_old),
        .load_data       (load_data),
        .write_overrun   (write_overrun)
    );

    // Graphics copies: old takes the pre-edge new value, so a simultaneous
    // copy and data commit moves the previous byte into the delay copy.
    always_ff @(posedge clock) begin
        if (reset) begin
            new_q <= 8'h00;
            old_q <= 8'h00;
        end else begin
            if (load_old) begin
                old_q <= new_q;
            end else begin
                old_q <= old_q;
            end
            if (load_new) begin
                new_q <= load_data;
            end else begin
                new_q <= new_q;
            end
        end
    end

    // Scan bit select; index 7 is the first pixel of a non-reflected sprite.
    always_comb begin
        idx     = {gs2, gs1, gs0};
        sel_new = grp_bit(new_q, idx);
        sel_old = grp_bit(old_q, idx);
    end

    generate
        if (REGISTER_OUTPUTS != 0) begin : g_reg_out
            logic new_r;
            logic old_r;

            // Registered readout: bits follow the scan index one clock later.
            always_ff @(posedge clock) begin
                if (reset) begin
                    new_r <= 1'b0;
                    old_r <= 1'b0;
                end else begin
                    new_r <= sel_new;
                    old_r <= sel_old;
                end
            end

            assign new_bit = new_r;
            assign old_bit = old_r;
        end else begin : g_comb_out
            assign new_bit = sel_new;
            assign old_bit = sel_old;
        end
    endgenerate

    assign grp_new = new_q;
    assign grp_old = old_q;

endmodule

// File: tb/tb_tia_player_graphics_register.sv
// Directed bench for the GRPx register pair: a transaction-level model with a
// per-cycle compare, plus literal expectations from the test plan.
module tb_tia_player_graphics_register;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] d = 8'h00;
    logic       grp_write = 1'b0;
    logic       other_grp_write = 1'b0;
    logic       commit = 1'b0;
    logic       gs0 = 1'b0, gs1 = 1'b0, gs2 = 1'b0;

    logic       c_new, c_old, c_ovr;
    logic [7:0] c_gnew, c_gold;
    logic       r_new, r_old, r_ovr;
    logic [7:0] r_gnew, r_gold;

    int total = 0;
    int bad   = 0;

    tia_player_graphics_register #(.REGISTER_OUTPUTS(0)) dut_c (
        .clock(clock), .reset(reset), .d(d), .grp_write(grp_write),
        .other_grp_write(other_grp_write), .commit(commit),
        .gs0(gs0), .gs1(gs1), .gs2(gs2),
        .new_bit(c_new), .old_bit(c_old), .grp_new(c_gnew), .grp_old(c_gold),
        .write_overrun(c_ovr)
    );

    tia_player_graphics_register #(.REGISTER_OUTPUTS(1)) dut_r (
        .clock(clock), .reset(reset), .d(d), .grp_write(grp_write),
        .other_grp_write(other_grp_write), .commit(commit),
        .gs0(gs0), .gs1(gs1), .gs2(gs2),
        .new_bit(r_new), .old_bit(r_old), .grp_new(r_gnew), .grp_old(r_gold),
        .write_overrun(r_ovr)
    );

    always #5 clock = ~clock;

    // Model: the visible byte pair, a list of uncommitted data writes (last
    // one wins) and a copy request.
    logic [7:0] m_new, m_old;
    logic [7:0] m_writes[$];
    logic       m_copy_req;
    logic       m_ovr;
    logic       m_rnew, m_rold;
    bit         check_en = 1'b0;

    always @(posedge clock) begin
        int k;
        k = {gs2, gs1, gs0};
        if (reset) begin
            m_new = 8'h00; m_old = 8'h00; m_writes.delete();
            m_copy_req = 1'b0; m_ovr = 1'b0; m_rnew = 1'b0; m_rold = 1'b0;
            check_en = 1'b1;
        end else begin
            m_rnew = m_new[k];
            m_rold = m_old[k];
            if (grp_write) begin
                if (m_writes.size() > 0 && !commit) m_ovr = 1'b1;
                m_writes.push_back(d);
            end
            if (other_grp_write) m_copy_req = 1'b1;
            if (commit) begin
                if (m_copy_req) m_old = m_new;
                if (m_writes.size() > 0) m_new = m_writes[$];
                m_writes.delete();
                m_copy_req = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        int k;
        if (check_en) begin
            k = {gs2, gs1, gs0};
            chk("c_new_bit", {7'd0, c_new}, {7'd0, m_new[k]});
            chk("c_old_bit", {7'd0, c_old}, {7'd0, m_old[k]});
            chk("c_grp_new", c_gnew, m_new);
            chk("c_grp_old", c_gold, m_old);
            chk("c_overrun", {7'd0, c_ovr}, {7'd0, m_ovr});
            chk("r_new_bit", {7'd0, r_new}, {7'd0, m_rnew});
            chk("r_old_bit", {7'd0, r_old}, {7'd0, m_rold});
            chk("r_grp_new", r_gnew, m_new);
            chk("r_overrun", {7'd0, r_ovr}, {7'd0, m_ovr});
        end
    end

    // Advance one cycle and apply the next input vector just after the edge.
    task automatic drive(input logic rst, input logic gw, input logic [7:0] dv,
                         input logic ow, input logic cm, input logic [2:0] gs);
        @(posedge clock);
        #1;
        reset = rst; grp_write = gw; d = dv; other_grp_write = ow; commit = cm;
        {gs2, gs1, gs0} = gs;
    endtask

    task automatic idle(input logic [2:0] gs);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, gs);
    endtask

    task automatic at_neg();
        @(negedge clock);
    endtask

    initial begin
        // Reset, then sweep the scan index over a cleared register pair.
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0);
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 8; i++) idle(i[2:0]);
        at_neg();
        chk("rst_grp_new", c_gnew, 8'h00);
        chk("rst_grp_old", c_gold, 8'h00);
        chk("rst_overrun", {7'd0, c_ovr}, 8'h00);

        // Write 0xA5, commit two cycles later.
        drive(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 3'd7);
        idle(3'd7);
        at_neg();
        chk("a5_before_commit", c_gnew, 8'h00);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 3'd7);
        at_neg();
        chk("a5_not_yet", c_gnew, 8'h00);
        idle(3'd7);
        at_neg();
        chk("a5_committed", c_gnew, 8'hA5);
        chk("a5_gs7", {7'd0, c_new}, 8'h01);
        idle(3'd6);
        at_neg();
        chk("a5_gs6", {7'd0, c_new}, 8'h00);
        idle(3'd0);
        at_neg();
        chk("a5_gs0", {7'd0, c_new}, 8'h01);

        // Commit with nothing pending leaves everything alone.
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 3'd0);
        idle(3'd0);
        at_neg();
        chk("empty_commit", c_gnew, 8'hA5);

        // Load 0x3C with a coincident commit, then write 0xFF plus copy.
        drive(1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 3'd2);
        drive(1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 3'd2);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 3'd2);
        idle(3'd2);
        at_neg();
        chk("vdel_old", c_gold, 8'h3C);
        chk("vdel_new", c_gnew, 8'hFF);
        chk("vdel_old_bit", {7'd0, c_old}, 8'h01);

        // Overrun: 0x11 replaced by 0x22 before commit.
        drive(1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 3'd4);
        drive(1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 3'd4);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 3'd4);
        idle(3'd5);
        at_neg();
        chk("ovr_last_wins", c_gnew, 8'h22);
        chk("ovr_flag", {7'd0, c_ovr}, 8'h01);
        for (int i = 0; i < 4; i++) idle(3'd1);
        at_neg();
        chk("ovr_sticky", {7'd0, c_ovr}, 8'h01);

        // Staged 0x81 discarded by reset; a later commit changes nothing.
        drive(1'b0, 1'b1, 8'h81, 1'b0, 1'b0, 3'd0);
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 3'd0);
        idle(3'd7);
        at_neg();
        chk("rst_discard_new", c_gnew, 8'h00);
        chk("rst_clears_ovr", {7'd0, c_ovr}, 8'h00);

        // Repeated copy requests do not flag an overrun.
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0);
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 3'd0);
        idle(3'd0);
        at_neg();
        chk("copy_no_ovr", {7'd0, c_ovr}, 8'h00);

        // Registered readout: 0x80, gs 0 -> 7, new follows one clock later.
        drive(1'b0, 1'b1, 8'h80, 1'b0, 1'b1, 3'd0);
        idle(3'd0);
        idle(3'd0);
        idle(3'd7);
        at_neg();
        chk("reg_lag_c", {7'd0, c_new}, 8'h01);
        chk("reg_lag_r0", {7'd0, r_new}, 8'h00);
        idle(3'd7);
        at_neg();
        chk("reg_lag_r1", {7'd0, r_new}, 8'h01);
        idle(3'd3);
        idle(3'd3);
        at_neg();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tia_player_graphics_register.md
Name: tia_player_graphics_register

Overview:
Holds one player's graphics byte (GRPx) as a "new" copy and a vertical-delay "old" copy. It also serves the scan-index side of the player graphics path. Each clock it returns the bit selected by the 3-bit scan index gs0..gs2 from both copies, as `new` and `old`. These two bits feed the player graphics scan counter, which applies vertical-delay selection. CPU writes are staged and committed on a colour-clock-aligned strobe, as in the TIA write path.

Parameters:
- GRP_WIDTH, 8, graphics register width. Fixed at 8; other values are unsupported.
- REGISTER_OUTPUTS, 0. 0 = `new`/`old` are combinational from the registers and gs. 1 = `new`/`old` are registered, adding one clock of latency.

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- d  input  8  CPU data bus value for a GRPx write
- grp_write  input  1  one-cycle strobe: this player's GRP register is addressed
- other_grp_write  input  1  one-cycle strobe: the other player's GRP register is addressed (VDEL copy trigger)
- commit  input  1  colour-clock-aligned strobe; staged writes take effect on it
- gs0, gs1, gs2  input  1 each  scan bit index, gs0 = LSB (already reflect-adjusted upstream)
- new  output  1  grp_new[gs]
- old  output  1  grp_old[gs]
- grp_new  output  8  current new copy (debug/readback)
- grp_old  output  8  current old copy (debug/readback)
- write_overrun  output  1  sticky: a staged write was replaced before commit

Behaviour:
- Reset (reset=1 at an edge):
  - grp_new, grp_old, staged data, both pending flags and write_overrun go to 0.
  - `new` and `old` read 0 from the following cycle onward.
  - Reset has priority over every other input on the same edge.
- Staging:
  - grp_write=1 captures d into stage_data and sets pend_new.
  - other_grp_write=1 sets pend_copy.
  - Both strobes may arrive in the same cycle; both are staged.
- Commit: on an edge with commit=1 and any pend_* set:
  - If pend_copy: grp_old <= grp_new, using the value before this edge.
  - If pend_new: grp_new <= stage_data.
  - Both pending flags clear.
  - With both pending, old receives the pre-commit new value, not stage_data.
- Strobe coincident with commit:
  - A grp_write or other_grp_write in the same cycle as commit=1 is committed on that same edge.
  - The d value in that cycle is used.
- Overrun:
  - grp_write while pend_new=1 and commit=0 replaces stage_data (last write wins) and sets write_overrun.
  - other_grp_write while pend_copy=1 has no additional effect and does not flag.
  - write_overrun clears only on reset.
- Commit with nothing pending: no state change.
- Readout:
  - idx = {gs2,gs1,gs0}; new = grp_new[idx]; old = grp_old[idx].
  - idx=7 selects d7, the first pixel of a non-reflected sprite.
  - REGISTER_OUTPUTS=0: zero latency from gs and from a committed update.
  - REGISTER_OUTPUTS=1: outputs follow one clock after gs changes.
- Reset mid-stage: staged data is discarded and no commit occurs afterward until a new strobe.
- No arithmetic. Index wrap is not possible: 3-bit index into 8 bits.

Decomposition:
- Shared package tia_pkg:
  - GRP_WIDTH = 8
  - GS_WIDTH = 3
  - typedef grp_t (8-bit)
  - typedef gs_idx_t (3-bit)
- One natural sub-module: tia_grp_write_stage, holding stage_data, pend_new, pend_copy, overrun and commit logic.
- The bit-select mux stays in the top level.

Test Plan:
- Reset, then gs sweep 0..7 -> new=0, old=0 for all indices; grp_new=grp_old=0x00; write_overrun=0.
- grp_write d=0xA5, commit two cycles later -> grp_new=0xA5 from commit edge, unchanged before. gs=7 -> new=1; gs=6 -> new=0; gs=0 -> new=1.
- grp_new=0x3C; same-cycle grp_write d=0xFF and other_grp_write, then commit -> grp_old=0x3C, grp_new=0xFF.
- grp_write d=0x11 then grp_write d=0x22 with no commit between, then commit -> grp_new=0x22, write_overrun=1 and stays 1 until reset.
- grp_write d=0x81 staged, reset asserted before commit, then commit -> grp_new=0x00, no pending state survives.
- REGISTER_OUTPUTS=1, grp_new=0x80, gs changes 0->7 -> new goes 0->1 exactly one clock after the gs change.
